// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder that reuses a single 1-bit full adder.
// Operands are captured on an accepted start and added LSB first, one bit per clock.
// The result, carry-out and signed overflow are held from done until the next accepted start.
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds a `sub` input for a-b).
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   start     request, sampled only when not busy
//   a, b      WIDTH-bit operands captured with start
//   cin       initial carry-in captured with start
//   sub       (SERIAL_ADDER_SUB_EN only) 1 = subtract b from a
//   busy      high while bits are being processed
//   done      one-cycle result-valid pulse
//   sum       WIDTH-bit result
//   cout      final carry-out (for subtract: 1 = no borrow)
//   overflow  signed overflow (carry into MSB xor carry out of MSB)
module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             load;
   logic             fa_x, fa_s, fa_co;

   // Shared 1-bit structural full adder
   assign fa_x  = a_sh_q[0] ^ b_sh_q[0];
   assign fa_s  = fa_x ^ carry_q;
   assign fa_co = (a_sh_q[0] & b_sh_q[0]) | (carry_q & fa_x);

   // Next-state and datapath control
   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      load    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) load = 1'b1;
         end
         S_RUN: begin
            res_d            = res_q >> 1;
            res_d[WIDTH-1]   = fa_s;
            a_sh_d           = a_sh_q >> 1;
            b_sh_d           = b_sh_q >> 1;
            carry_d          = fa_co;
            cnt_d            = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               // carry_q is the carry into the MSB on this final bit
               sum_d   = res_d;
               cout_d  = fa_co;
               ovf_d   = carry_q ^ fa_co;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               busy_d = 1'b1;
            end
         end
         S_DONE: begin
            if (start) load = 1'b1;
            else       state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (load) begin
         a_sh_d  = a;
`ifdef SERIAL_ADDER_SUB_EN
         b_sh_d  = sub ? ~b : b;
         carry_d = sub ? 1'b1 : cin;
`else
         b_sh_d  = b;
         carry_d = cin;
`endif
         cnt_d   = '0;
         busy_d  = 1'b1;
         state_d = S_RUN;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed checks of serial_adder_ctrl at WIDTH=8 plus a WIDTH=4 sweep.
module tb_serial_adder_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start8, cin8;
   logic [7:0] a8, b8;
   logic       busy8, done8, cout8, ovf8;
   logic [7:0] sum8;
   logic       start4, cin4;
   logic [3:0] a4, b4;
   logic       busy4, done4, cout4, ovf4;
   logic [3:0] sum4;
`ifdef SERIAL_ADDER_SUB_EN
   logic       sub8;
   logic       sub4;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
      .clk(clk), .reset_n(reset_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub8),
`endif
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
   );

   serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
      .clk(clk), .reset_n(reset_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub4),
`endif
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One isolated WIDTH=8 operation; operands are scrambled and start pulsed while busy.
   task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic ci, input logic sb,
                      input logic [7:0] es, input logic ec, input logic eo);
      int nbusy;
      int dcyc;
      a8 = av; b8 = bv; cin8 = ci; start8 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
      sub8 = sb;
`else
      if (sb) $display("note: %s uses sub but the feature is not built", tag);
`endif
      @(negedge clk);
      start8 = 1'b0; a8 = ~av; b8 = 8'h5A; cin8 = ~ci;
      nbusy = 0; dcyc = 0;
      for (int i = 1; i <= 20 && dcyc == 0; i++) begin
         if (busy8) nbusy++;
         if (done8) dcyc = i;
         if (i == 3) start8 = 1'b1;
         if (i == 4) start8 = 1'b0;
         if (dcyc == 0) @(negedge clk);
      end
      chk({tag, "_busy_cycles"}, 32'(nbusy), 32'd8);
      chk({tag, "_done_cycle"}, 32'(dcyc), 32'd9);
      chk({tag, "_sum"}, 32'(sum8), 32'(es));
      chk({tag, "_cout"}, 32'(cout8), 32'(ec));
      chk({tag, "_ovf"}, 32'(ovf8), 32'(eo));
      @(negedge clk);
      chk({tag, "_held_sum"}, 32'(sum8), 32'(es));
      chk({tag, "_done_pulse"}, 32'(done8), 32'd0);
   endtask

   task automatic wait_done8(output int n);
      n = 0;
      while (!done8 && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   // WIDTH=4 op issued back-to-back with the previous one when called in its done cycle.
   task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic ci);
      int n;
      logic [4:0] exp;
      logic [3:0] es;
      a4 = av; b4 = bv; cin4 = ci; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      n = 0;
      while (!done4 && n < 10) begin
         @(negedge clk);
         n++;
      end
      exp = 5'(av) + 5'(bv) + 5'(ci);
      es  = exp[3:0];
      chk("sweep_lat", 32'(n), 32'd4);
      chk("sweep_sum", 32'({cout4, sum4}), 32'(exp));
      chk("sweep_ovf", 32'(ovf4), 32'((av[3] == bv[3]) && (es[3] != av[3])));
   endtask

   logic [7:0] ba [3];
   logic [7:0] bb [3];
   logic       bc [3];
   logic [7:0] bs [3];
   logic       bo [3];
   logic       bov[3];

   initial begin
      int n;
      reset_n = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub8 = 1'b0; sub4 = 1'b0;
`endif
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy8), 32'd0);
      chk("rst_done", 32'(done8), 32'd0);
      chk("rst_sum", 32'(sum8), 32'd0);
      chk("rst_cout", 32'(cout8), 32'd0);
      chk("rst_ovf", 32'(ovf8), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      op8("add35_4a", 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0);
      op8("ff_cin1",  8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      op8("7f_01",    8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      op8("ff_01",    8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

      // Back-to-back with start held high
      ba[0] = 8'h12; bb[0] = 8'h34; bc[0] = 1'b0; bs[0] = 8'h46; bo[0] = 1'b0; bov[0] = 1'b0;
      ba[1] = 8'hF0; bb[1] = 8'h0F; bc[1] = 1'b1; bs[1] = 8'h00; bo[1] = 1'b1; bov[1] = 1'b0;
      ba[2] = 8'h80; bb[2] = 8'h80; bc[2] = 1'b0; bs[2] = 8'h00; bo[2] = 1'b1; bov[2] = 1'b1;
      a8 = ba[0]; b8 = bb[0]; cin8 = bc[0]; start8 = 1'b1;
      @(negedge clk);
      a8 = ba[1]; b8 = bb[1]; cin8 = bc[1];
      for (int j = 0; j < 3; j++) begin
         wait_done8(n);
         chk("b2b_gap", 32'(n + 1), 32'd9);
         chk("b2b_sum", 32'(sum8), 32'(bs[j]));
         chk("b2b_cout", 32'(cout8), 32'(bo[j]));
         chk("b2b_ovf", 32'(ovf8), 32'(bov[j]));
         @(negedge clk);
         if (j < 2) chk("b2b_no_bubble", 32'(busy8), 32'd1);
         if (j == 0) begin
            a8 = ba[2]; b8 = bb[2]; cin8 = bc[2];
         end else begin
            start8 = 1'b0;
         end
      end
      @(negedge clk);

      // Reset in the middle of RUN aborts the op and clears the result
      op8("pre_rst", 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0);
      a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (4) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy8), 32'd0);
      chk("midrst_sum", 32'(sum8), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done8) n++;
      end
      chk("midrst_no_done", 32'(n), 32'd0);
      op8("post_rst", 8'h01, 8'h02, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
      op8("sub10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0);
      op8("sub80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
      sub8 = 1'b0;
`endif

      // Exhaustive WIDTH=4 sweep
      for (int ia = 0; ia < 16; ia++)
         for (int ib = 0; ib < 16; ib++)
            for (int ic = 0; ic < 2; ic++)
               op4(4'(ia), 4'(ib), 1'(ic));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
